// File: rtl/ext_int_controller_if.sv
// Core-side interrupt handshake between the EIC and the Kabeta interrupt unit.
// The master drives the request and ID; the slave (core) returns a one-cycle ack.
interface ext_int_controller_if #(
    parameter int ID_W = 1
);
    logic            EIC_IntReq;
    logic [ID_W-1:0] EIC_IntId;
    logic            EIC_IntAck;

    modport master (output EIC_IntReq, output EIC_IntId, input EIC_IntAck);
    modport slave  (input EIC_IntReq, input EIC_IntId, output EIC_IntAck);
endinterface

// File: rtl/ext_int_controller.sv
// External interrupt controller: sync + edge detect, pending/mask, one-at-a-time grant.
// Define EIC_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module ext_int_controller #(
    parameter int ID_W    = 1,
    parameter int NUM_SRC = 2
) (
    input  logic               Sys_Clock,
    input  logic               Sys_Reset,
    input  logic [NUM_SRC-1:0] Src_Irq,
    input  logic               Cfg_MaskWe,
    input  logic [NUM_SRC-1:0] Cfg_MaskIn,
    output logic [NUM_SRC-1:0] Cfg_Mask,
    output logic [NUM_SRC-1:0] Int_Pending,
    ext_int_controller_if.master eic
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] sync3;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] ack_clear;
    logic [ID_W-1:0]    winner;

    // Two flops for metastability, the third only feeds the edge detector.
    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= Src_Irq;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise     = sync2 & ~sync3;
    assign eligible = Int_Pending & ~Cfg_Mask;

    always_comb begin
        ack_clear = '0;
        if (state == REQ && eic.EIC_IntAck) begin
            ack_clear[eic.EIC_IntId] = 1'b1;
        end
    end

    // OR-ing rise after the clear lets a new event survive a same-cycle ack.
    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) begin
            Int_Pending <= '0;
            Cfg_Mask    <= '0;
        end else begin
            Int_Pending <= (Int_Pending & ~ack_clear) | rise;
            if (Cfg_MaskWe) begin
                Cfg_Mask <= Cfg_MaskIn;
            end
        end
    end

`ifdef EIC_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_granted;
    logic [ID_W-1:0] probe;
    logic            found;

    // NUM_SRC is a power of two, so ID_W-bit wraparound gives the modulo.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        probe  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            probe = last_granted + ID_W'(1) + ID_W'(k);
            if (!found && eligible[probe]) begin
                winner = probe;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) begin
            last_granted <= '0;
        end else if (state == REQ && eic.EIC_IntAck) begin
            last_granted <= eic.EIC_IntId;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                winner = ID_W'(k);
            end
        end
    end
`endif

    // The request is held through REQ regardless of later mask or pending changes.
    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) begin
            state          <= IDLE;
            eic.EIC_IntReq <= 1'b0;
            eic.EIC_IntId  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        eic.EIC_IntId  <= winner;
                        eic.EIC_IntReq <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (eic.EIC_IntAck) begin
                        eic.EIC_IntReq <= 1'b0;
                        state          <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    eic.EIC_IntReq <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_int_controller.sv
// Directed bench for ext_int_controller; grant IDs are checked against a scoreboard queue.
// Expected grant order follows EIC_ROUND_ROBIN_EN when it is defined.
module tb_ext_int_controller;

    logic       Sys_Clock = 1'b0;
    logic       Sys_Reset;
    logic [1:0] Src_Irq;
    logic       Cfg_MaskWe;
    logic [1:0] Cfg_MaskIn;
    logic [1:0] Cfg_Mask;
    logic [1:0] Int_Pending;

    int assert_count = 0;
    int fail_count   = 0;
    int exp_q[$];

    ext_int_controller_if #(.ID_W(1)) eic_bus ();

    ext_int_controller #(.ID_W(1), .NUM_SRC(2)) dut (
        .Sys_Clock   (Sys_Clock),
        .Sys_Reset   (Sys_Reset),
        .Src_Irq     (Src_Irq),
        .Cfg_MaskWe  (Cfg_MaskWe),
        .Cfg_MaskIn  (Cfg_MaskIn),
        .Cfg_Mask    (Cfg_Mask),
        .Int_Pending (Int_Pending),
        .eic         (eic_bus)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    task automatic tick();
        @(posedge Sys_Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One-cycle pulse on the raw lines; the first sampling edge is the tick inside.
    task automatic applyStimulus(input logic [1:0] bits);
        Src_Irq = bits;
        tick();
        Src_Irq = 2'b00;
    endtask

    task automatic pulseAck();
        eic_bus.EIC_IntAck = 1'b1;
        tick();
        eic_bus.EIC_IntAck = 1'b0;
    endtask

    task automatic writeMask(input logic [1:0] value);
        Cfg_MaskIn = value;
        Cfg_MaskWe = 1'b1;
        tick();
        Cfg_MaskWe = 1'b0;
    endtask

    task automatic waitGrant(input string tag);
        int n = 0;
        int expected;
        while (eic_bus.EIC_IntReq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_req"}, 32'(eic_bus.EIC_IntReq), 32'd1);
        expected = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
        checkOutput({tag, "_id"}, 32'(eic_bus.EIC_IntId), 32'(expected));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Sys_Reset          = 1'b1;
        Src_Irq            = 2'b00;
        Cfg_MaskWe         = 1'b0;
        Cfg_MaskIn         = 2'b00;
        eic_bus.EIC_IntAck = 1'b0;
        tick();
        checkOutput("rst_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        checkOutput("rst_id", 32'(eic_bus.EIC_IntId), 32'd0);
        checkOutput("rst_pend", 32'(Int_Pending), 32'd0);
        checkOutput("rst_mask", 32'(Cfg_Mask), 32'd0);
        Sys_Reset = 1'b0;
        tick();
        tick();

        $display("[TB] latency: single source 0");
        exp_q.push_back(0);
        applyStimulus(2'b01);
        checkOutput("lat_e0_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("lat_e1_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("lat_e2_pend", 32'(Int_Pending), 32'h1);
        checkOutput("lat_e2_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("lat_e3_req", 32'(eic_bus.EIC_IntReq), 32'd1);
        waitGrant("lat_e3");
        pulseAck();
        checkOutput("lat_ack_pend", 32'(Int_Pending), 32'd0);
        checkOutput("lat_gap_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("lat_idle_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("lat_stay_req", 32'(eic_bus.EIC_IntReq), 32'd0);

        $display("[TB] simultaneous sources");
`ifdef EIC_ROUND_ROBIN_EN
        exp_q.push_back(1);
        exp_q.push_back(0);
`else
        exp_q.push_back(0);
        exp_q.push_back(1);
`endif
        applyStimulus(2'b11);
        waitGrant("sim_first");
        pulseAck();
        checkOutput("sim_gap_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("sim_idle_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("sim_second_req", 32'(eic_bus.EIC_IntReq), 32'd1);
        waitGrant("sim_second");
        pulseAck();
        checkOutput("sim_done_pend", 32'(Int_Pending), 32'd0);

        $display("[TB] mask holds source 1 pending");
        writeMask(2'b10);
        checkOutput("mask_reg", 32'(Cfg_Mask), 32'h2);
        exp_q.push_back(1);
        applyStimulus(2'b10);
        tick();
        tick();
        checkOutput("mask_pend", 32'(Int_Pending), 32'h2);
        tick();
        tick();
        checkOutput("mask_no_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        writeMask(2'b00);
        checkOutput("unmask_edge_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("unmask_next_req", 32'(eic_bus.EIC_IntReq), 32'd1);
        waitGrant("unmask");
        pulseAck();

        $display("[TB] repeated pulses with set/clear collision");
`ifdef EIC_ROUND_ROBIN_EN
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(0);
`else
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(1);
`endif
        applyStimulus(2'b11);
        for (int i = 0; i < 4; i++) begin
            waitGrant($sformatf("rep%0d", i));
            if (i < 3) begin
                applyStimulus(2'b11);
                tick();
                pulseAck();
                checkOutput($sformatf("collide%0d_pend", i), 32'(Int_Pending), 32'h3);
            end else begin
                pulseAck();
            end
        end
        waitGrant("rep_drain");
        pulseAck();
        checkOutput("rep_done_pend", 32'(Int_Pending), 32'd0);

        $display("[TB] spurious ack in IDLE");
        writeMask(2'b01);
        applyStimulus(2'b01);
        tick();
        tick();
        checkOutput("spur_pre_pend", 32'(Int_Pending), 32'h1);
        pulseAck();
        checkOutput("spur_pend", 32'(Int_Pending), 32'h1);
        checkOutput("spur_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        tick();
        checkOutput("spur_later_req", 32'(eic_bus.EIC_IntReq), 32'd0);

        $display("[TB] async reset during REQ");
        exp_q.push_back(0);
        writeMask(2'b00);
        waitGrant("rst_mid");
        #2;
        Sys_Reset = 1'b1;
        #1;
        checkOutput("rst_mid_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        checkOutput("rst_mid_pend", 32'(Int_Pending), 32'd0);
        checkOutput("rst_mid_id", 32'(eic_bus.EIC_IntId), 32'd0);
        tick();
        Sys_Reset = 1'b0;
        tick();
        tick();
        checkOutput("rst_after_req", 32'(eic_bus.EIC_IntReq), 32'd0);
        checkOutput("rst_after_pend", 32'(Int_Pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
